regfile_alu_datapath: RTL and testbench
=======================================

# regfile_alu_datapath

Parametrised register-file plus ALU datapath with instruction handshake, write-enable, status flags and multi-cycle barrel-free shifts. It executes one control word per accepted instruction: it reads two operands, computes, then writes the destination register and the flag register. It is the execution core between the instruction sequencer and the output port.

## Interface

- WIDTH, 8: data width in bits (>=4).
- NREGS, 8: register addresses, power of two. Address 0 reads `in` and its writes are discarded.
- AW, $clog2(NREGS): register address width (derived).
- clk  in  1  clock, rising edge.
- rst  in  1  reset. Synchronous and active-high.
- in  in  WIDTH  external operand, read via address 0.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  datapath can accept an instruction.
- src_a  in  AW  operand A address.
- src_b  in  AW  operand B address.
- dst  in  AW  destination address.
- op  in  5  opcode.
- out  out  WIDTH  registered result of the last completed instruction.
- out_valid  out  1  one-cycle pulse when `out`/flags are updated.
- out_err  out  1  one-cycle pulse, undefined opcode completed.
- flags  out  4  {V,C,N,Z}, registered.

## Operation

- Opcodes: PASS 00000 (A); INC 00001; ADD 00010; SUB 00101 (A-B); DEC 00110; AND 01000; OR 01010; XOR 01100; NOT 01110 (~A); SHR1 10000; SHL1 11000; SHRN 10001; SHLN 11001.
- Shift amount for SHRN and SHLN = B[$clog2(WIDTH)-1:0]. Shifts are logical with zero fill.
- Arithmetic is modulo 2^WIDTH.
- Flag Z = (result==0). Flag N = result[WIDTH-1].
- Flag C is the carry-out for ADD and INC. It is the borrow (A<B unsigned, or A==0 for DEC) for SUB and DEC. It is the last bit shifted out for shifts, and 0 for shift by 0. It is 0 for logic ops and PASS.
- Flag V is the signed overflow for ADD, SUB, INC and DEC. It is 0 otherwise.
- Undefined opcode: out is set to 0 and out_err pulses. There is no register write and flags are unchanged.
- FSM has two states, IDLE and SHIFT.
  - IDLE: instr_ready=1. On an accept edge (instr_valid & instr_ready), a single-cycle op completes at that edge: dst, out and flags are written, and out_valid pulses in the next cycle.
  - IDLE: for SHRN or SHLN, the accept edge latches A, count and dst, then the FSM goes to SHIFT.
  - SHIFT: instr_ready=0. Each cycle shifts one bit and decrements count.
  - SHIFT: when count==0 at a clock edge, the FSM writes dst, out and flags and returns to IDLE.
- Operands are read at the accept edge. Register values written by instruction n are visible to instruction n+1 accepted on the following edge (no hazard).
- instr_valid during SHIFT is ignored. The producer must hold the instruction until ready.

## Timing

- Reset, taking effect at the next edge regardless of state:
  - all registers, out and flags are 0;
  - out_valid=0 and out_err=0;
  - state is IDLE, so instr_ready=1 in the cycle after reset;
  - an in-flight shift is abandoned with no write.
- Single-cycle op latency: out_valid goes high 1 cycle after the accept edge. Throughput is one instruction per cycle.
- Shift of k (0..WIDTH-1) latency: k+1 edges after accept. instr_ready is low for k+1 cycles.
- out and flags hold their values between completions.

## Structure

- `datapath_pkg` holds:
  - the opcode localparams;
  - the flag bit indices (Z=0, N=1, C=2, V=3);
  - the IDLE/SHIFT state encoding.
- Sub-module `alu_core` is purely combinational. It takes A, B and op and produces the result, the C/V flags and an invalid indication for single-cycle ops.
- The top level holds the register array, the operand muxes, the shift FSM and the output registers.

## Test plan

All scenarios use WIDTH=4 and NREGS=8.

1. Reset mid-SHLN (count 3, after 1 shift) -> next cycle instr_ready=1, out=0, flags=0, the target register stays 0, and no out_valid.
2. in=0x7, PASS dst=1, then ADD src_a=1 src_b=1 dst=2 back-to-back -> out=0xE, flags V=1,N=1,C=0,Z=0, with out_valid on consecutive cycles.
3. R1=0x3, SUB A=in(0x2) B=R1 -> out=0xF, C=1, N=1, V=0. Then DEC from R0 with in=0 -> 0xF, C=1.
4. R1=0xB, in=0x3, SHLN A=R1 B=in -> instr_ready low 4 cycles, instr_valid held and ignored meanwhile, out=0x8, C=1. SHRN with B=0 -> 1 cycle, out=A, C=0.
5. Write with dst=0, then read address 0 -> returns in, not the written value.
6. op=00011 -> out_err pulse, out=0, flags and registers unchanged. Then INC on 0xF -> out=0, Z=1, C=1.

Source files
------------

// File: rtl/datapath_pkg.sv
// datapath_pkg: opcodes, flag bit positions and FSM state encoding shared by the datapath.
package datapath_pkg;
  localparam logic [4:0] OP_PASS = 5'b00000;
  localparam logic [4:0] OP_INC  = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00101;
  localparam logic [4:0] OP_DEC  = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_XOR  = 5'b01100;
  localparam logic [4:0] OP_NOT  = 5'b01110;
  localparam logic [4:0] OP_SHR1 = 5'b10000;
  localparam logic [4:0] OP_SHL1 = 5'b11000;
  localparam logic [4:0] OP_SHRN = 5'b10001;
  localparam logic [4:0] OP_SHLN = 5'b11001;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_e;
  function automatic logic [3:0] mk_flags(input logic v, input logic c, input logic n, input logic z);
    logic [3:0] f;
    f = '0;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU for all single-cycle opcodes; flags anything else as invalid.
module alu_core
  import datapath_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             c,
  output logic             v,
  output logic             invalid
);
  localparam int M = WIDTH - 1;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  // INC/DEC reuse the add/subtract paths with an implicit operand of one
  assign rhs  = (op == OP_INC || op == OP_DEC) ? WIDTH'(1) : b;
  assign sum  = {1'b0, a} + {1'b0, rhs};
  assign diff = {1'b0, a} - {1'b0, rhs};
  always_comb begin
    res = '0;
    c = 1'b0;
    v = 1'b0;
    invalid = 1'b0;
    case (op)
      OP_PASS: res = a;
      OP_INC, OP_ADD: begin
        res = sum[M:0];
        c = sum[WIDTH];
        v = (a[M] == rhs[M]) && (sum[M] != a[M]);
      end
      OP_SUB, OP_DEC: begin
        res = diff[M:0];
        c = diff[WIDTH];
        v = (a[M] != rhs[M]) && (diff[M] != a[M]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHR1: begin
        res = {1'b0, a[M:1]};
        c = a[0];
      end
      OP_SHL1: begin
        res = {a[M-1:0], 1'b0};
        c = a[M];
      end
      default: invalid = 1'b1;
    endcase
  end
endmodule

// File: rtl/regfile_alu_datapath.sv
// regfile_alu_datapath: register file, operand muxes, ALU and one-bit-per-cycle shift FSM.
module regfile_alu_datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  input  logic [AW-1:0]    dst,
  input  logic [4:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             out_err,
  output logic [3:0]       flags
);
  localparam int M  = WIDTH - 1;
  localparam int SW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] out_q, out_d, sh_val_q, sh_val_d;
  logic [3:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic [SW-1:0]    sh_cnt_q, sh_cnt_d;
  logic [AW-1:0]    sh_dst_q, sh_dst_d;
  logic             sh_left_q, sh_left_d, sh_c_q, sh_c_d;
  logic [WIDTH-1:0] a, b, alu_res;
  logic             alu_c, alu_v, alu_inv, is_shn;
  // address 0 is the external operand, never the stored entry
  assign a = (src_a == '0) ? in : regs_q[src_a];
  assign b = (src_b == '0) ? in : regs_q[src_b];
  assign is_shn = (op == OP_SHRN) || (op == OP_SHLN);
  assign instr_ready = (state_q == S_IDLE);
  assign out = out_q;
  assign out_valid = out_valid_q;
  assign out_err = out_err_q;
  assign flags = flags_q;
  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a(a),
    .b(b),
    .op(op),
    .res(alu_res),
    .c(alu_c),
    .v(alu_v),
    .invalid(alu_inv)
  );
  always_comb begin
    regs_d = regs_q;
    out_d = out_q;
    flags_d = flags_q;
    out_valid_d = 1'b0;
    out_err_d = 1'b0;
    state_d = state_q;
    sh_val_d = sh_val_q;
    sh_cnt_d = sh_cnt_q;
    sh_dst_d = sh_dst_q;
    sh_left_d = sh_left_q;
    sh_c_d = sh_c_q;
    if (state_q == S_IDLE && instr_valid) begin
      if (is_shn) begin
        sh_val_d = a;
        sh_cnt_d = b[SW-1:0];
        sh_dst_d = dst;
        sh_left_d = (op == OP_SHLN);
        sh_c_d = 1'b0;
        state_d = S_SHIFT;
      end else if (alu_inv) begin
        out_d = '0;
        out_err_d = 1'b1;
        out_valid_d = 1'b1;
      end else begin
        if (dst != '0) regs_d[dst] = alu_res;
        out_d = alu_res;
        flags_d = mk_flags(alu_v, alu_c, alu_res[M], alu_res == '0);
        out_valid_d = 1'b1;
      end
    end else if (state_q == S_SHIFT) begin
      if (sh_cnt_q == '0) begin
        if (sh_dst_q != '0) regs_d[sh_dst_q] = sh_val_q;
        out_d = sh_val_q;
        flags_d = mk_flags(1'b0, sh_c_q, sh_val_q[M], sh_val_q == '0);
        out_valid_d = 1'b1;
        state_d = S_IDLE;
      end else begin
        sh_val_d = sh_left_q ? {sh_val_q[M-1:0], 1'b0} : {1'b0, sh_val_q[M:1]};
        sh_c_d = sh_left_q ? sh_val_q[M] : sh_val_q[0];
        sh_cnt_d = sh_cnt_q - SW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      out_q <= '0;
      flags_q <= '0;
      out_valid_q <= 1'b0;
      out_err_q <= 1'b0;
      state_q <= S_IDLE;
      sh_val_q <= '0;
      sh_cnt_q <= '0;
      sh_dst_q <= '0;
      sh_left_q <= 1'b0;
      sh_c_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      out_q <= out_d;
      flags_q <= flags_d;
      out_valid_q <= out_valid_d;
      out_err_q <= out_err_d;
      state_q <= state_d;
      sh_val_q <= sh_val_d;
      sh_cnt_q <= sh_cnt_d;
      sh_dst_q <= sh_dst_d;
      sh_left_q <= sh_left_d;
      sh_c_q <= sh_c_d;
    end
  end
endmodule

// File: tb/tb_regfile_alu_datapath.sv
// tb_regfile_alu_datapath: directed scenarios plus randomized instructions against a behavioural model.
module tb_regfile_alu_datapath;
  localparam logic [4:0] PASS = 5'b00000, INC = 5'b00001, ADD = 5'b00010, SUB = 5'b00101;
  localparam logic [4:0] DEC = 5'b00110, AND_ = 5'b01000, OR_ = 5'b01010, XOR_ = 5'b01100;
  localparam logic [4:0] NOT_ = 5'b01110, SHR1 = 5'b10000, SHL1 = 5'b11000;
  localparam logic [4:0] SHRN = 5'b10001, SHLN = 5'b11001;
  logic clk = 0, rst = 0, instr_valid = 0, instr_ready, out_valid, out_err;
  logic [3:0] in = 0, out, flags;
  logic [2:0] src_a = 0, src_b = 0, dst = 0;
  logic [4:0] op = 0;
  int errors = 0, checks = 0;

  regfile_alu_datapath #(.WIDTH(4), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .in(in), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .src_a(src_a), .src_b(src_b), .dst(dst), .op(op), .out(out),
    .out_valid(out_valid), .out_err(out_err), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1;
    instr_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic send(input logic [4:0] o, input logic [3:0] iv, input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] d);
    int n = 0;
    op = o; in = iv; src_a = sa; src_b = sb; dst = d; instr_valid = 1;
    while (!instr_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!instr_ready) begin checks++; errors++; $display("FAIL send_timeout ready=%b required=1", instr_ready); end
    @(posedge clk);
    #1 instr_valid = 0;
  endtask

  function automatic void ref_exec(input logic [4:0] o, input int a, input int b, output int r, output int c,
                                   output int v, output bit err, output int lat);
    int sa, sb, k;
    sa = a > 7 ? a - 16 : a;
    sb = b > 7 ? b - 16 : b;
    k = b % 4;
    r = 0; c = 0; v = 0; err = 0; lat = 0;
    case (o)
      PASS: r = a;
      INC:  begin r = (a + 1) % 16; c = (a + 1 > 15); v = (sa + 1 > 7); end
      ADD:  begin r = (a + b) % 16; c = (a + b > 15); v = (sa + sb > 7) || (sa + sb < -8); end
      SUB:  begin r = (a - b + 16) % 16; c = (a < b); v = (sa - sb > 7) || (sa - sb < -8); end
      DEC:  begin r = (a + 15) % 16; c = (a == 0); v = (sa - 1 < -8); end
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      NOT_: r = 15 - a;
      SHR1: begin r = a / 2; c = a % 2; end
      SHL1: begin r = (a * 2) % 16; c = a / 8; end
      SHRN: begin r = a >> k; c = (k > 0) ? (a >> (k - 1)) & 1 : 0; lat = k + 1; end
      SHLN: begin r = (a << k) % 16; c = (k > 0) ? (a >> (4 - k)) & 1 : 0; lat = k + 1; end
      default: err = 1;
    endcase
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
    checks++; if (out !== 4'h0) begin errors++; $display("FAIL reset_out got=%h exp=0", out); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
  endtask

  task automatic test_reset_mid_shift();
    send(SHLN, 4'hB, 3'd0, 3'd0, 3'd3);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", instr_ready); end
    checks++; if (out !== 4'h0) begin errors++; $display("FAIL midrst_out got=%h exp=0", out); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL midrst_flags got=%b exp=0000", flags); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_valid cyc=%0d got=%b exp=0", i, out_valid); end
      @(posedge clk); #1;
    end
    send(PASS, 4'h0, 3'd3, 3'd0, 3'd0);
    checks++; if (out !== 4'h0) begin errors++; $display("FAIL midrst_r3 got=%h exp=0", out); end
    checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL midrst_r3_flags got=%b exp=0001", flags); end
  endtask

  task automatic test_back_to_back();
    send(PASS, 4'h7, 3'd0, 3'd0, 3'd1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got=%b exp=1", out_valid); end
    checks++; if (out !== 4'h7) begin errors++; $display("FAIL b2b_out1 got=%h exp=7", out); end
    send(ADD, 4'h7, 3'd1, 3'd1, 3'd2);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2 got=%b exp=1", out_valid); end
    checks++; if (out !== 4'hE) begin errors++; $display("FAIL b2b_out2 got=%h exp=e", out); end
    checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL b2b_flags got=%b exp=1010", flags); end
  endtask

  task automatic test_sub_dec();
    send(PASS, 4'h3, 3'd0, 3'd0, 3'd1);
    send(SUB, 4'h2, 3'd0, 3'd1, 3'd3);
    checks++; if (out !== 4'hF) begin errors++; $display("FAIL sub_out got=%h exp=f", out); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL sub_flags got=%b exp=0110", flags); end
    send(PASS, 4'h0, 3'd0, 3'd0, 3'd4);
    send(DEC, 4'h0, 3'd0, 3'd0, 3'd3);
    checks++; if (out !== 4'hF) begin errors++; $display("FAIL dec_out got=%h exp=f", out); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL dec_flags got=%b exp=0110", flags); end
  endtask

  task automatic test_shift();
    send(PASS, 4'hB, 3'd0, 3'd0, 3'd1);
    send(SHLN, 4'h3, 3'd1, 3'd0, 3'd4);
    op = PASS; src_a = 3'd0; dst = 3'd5; instr_valid = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL shln_busy cyc=%0d got=%b exp=0", i, instr_ready); end
      @(posedge clk); #1;
    end
    instr_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL shln_valid got=%b exp=1", out_valid); end
    checks++; if (out !== 4'h8) begin errors++; $display("FAIL shln_out got=%h exp=8", out); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL shln_flags got=%b exp=0110", flags); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL shln_held_ignored got=%b exp=0", out_valid); end
    send(PASS, 4'h0, 3'd5, 3'd0, 3'd0);
    checks++; if (out !== 4'h0) begin errors++; $display("FAIL shln_r5 got=%h exp=0", out); end
    send(SHRN, 4'h0, 3'd1, 3'd0, 3'd6);
    checks++; if (instr_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL shrn0_busy ready=%b valid=%b exp=0,0", instr_ready, out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL shrn0_valid got=%b exp=1", out_valid); end
    checks++; if (out !== 4'hB) begin errors++; $display("FAIL shrn0_out got=%h exp=b", out); end
    checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL shrn0_flags got=%b exp=0010", flags); end
  endtask

  task automatic test_r0();
    send(PASS, 4'h9, 3'd0, 3'd0, 3'd0);
    send(PASS, 4'h5, 3'd0, 3'd0, 3'd7);
    checks++; if (out !== 4'h5) begin errors++; $display("FAIL r0_read got=%h exp=5", out); end
    send(OR_, 4'h5, 3'd1, 3'd0, 3'd7);
    checks++; if (out !== 4'hF) begin errors++; $display("FAIL r0_srcb got=%h exp=f", out); end
  endtask

  task automatic test_undef();
    send(PASS, 4'h6, 3'd0, 3'd0, 3'd2);
    send(DEC, 4'h0, 3'd0, 3'd0, 3'd0);
    send(5'b00011, 4'h9, 3'd0, 3'd0, 3'd2);
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL undef_err got=%b exp=1", out_err); end
    checks++; if (out !== 4'h0) begin errors++; $display("FAIL undef_out got=%h exp=0", out); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL undef_flags got=%b exp=0110", flags); end
    @(posedge clk); #1;
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL undef_pulse got=%b exp=0", out_err); end
    send(PASS, 4'h0, 3'd2, 3'd0, 3'd0);
    checks++; if (out !== 4'h6) begin errors++; $display("FAIL undef_r2 got=%h exp=6", out); end
    send(INC, 4'hF, 3'd0, 3'd0, 3'd3);
    checks++; if (out !== 4'h0) begin errors++; $display("FAIL inc_out got=%h exp=0", out); end
    checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL inc_flags got=%b exp=0101", flags); end
  endtask

  task automatic test_random();
    logic [4:0] ops [16] = '{PASS, INC, ADD, SUB, DEC, AND_, OR_, XOR_, NOT_, SHR1, SHL1, SHRN, SHLN,
                             5'b00011, 5'b00100, 5'b11111};
    int mregs [8];
    logic [3:0] mflags, ef, iv;
    logic [4:0] o;
    logic [2:0] sa, sb, d;
    int av, bv, r, c, v, lat, cyc;
    bit err;
    do_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 0;
    mflags = 0;
    for (int t = 0; t < 80; t++) begin
      o = ops[$urandom_range(0, 15)];
      iv = 4'($urandom);
      sa = 3'($urandom); sb = 3'($urandom); d = 3'($urandom);
      av = (sa == 0) ? int'(iv) : mregs[sa];
      bv = (sb == 0) ? int'(iv) : mregs[sb];
      ref_exec(o, av, bv, r, c, v, err, lat);
      ef = err ? mflags : {v[0], c[0], r >= 8, r == 0};
      send(o, iv, sa, sb, d);
      cyc = 0;
      while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
      checks++; if (cyc !== lat) begin errors++; $display("FAIL rnd_latency t=%0d op=%b got=%0d exp=%0d", t, o, cyc, lat); end
      checks++; if (out_err !== err) begin errors++; $display("FAIL rnd_err t=%0d op=%b got=%b exp=%b", t, o, out_err, err); end
      checks++; if (out !== (err ? 4'h0 : r[3:0])) begin errors++; $display("FAIL rnd_out t=%0d op=%b a=%0d b=%0d got=%h exp=%h", t, o, av, bv, out, err ? 4'h0 : r[3:0]); end
      checks++; if (flags !== ef) begin errors++; $display("FAIL rnd_flags t=%0d op=%b a=%0d b=%0d got=%b exp=%b", t, o, av, bv, flags, ef); end
      if (!err) begin
        mflags = ef;
        if (d != 0) mregs[d] = r;
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_shift();
    test_back_to_back();
    test_sub_dec();
    test_shift();
    test_r0();
    test_undef();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
